// File: rtl/ekf_stage_ctrl_if.sv
// ekf_stage_ctrl_if
//   Bundles the host command channel, the per-stage request/ready handshake
//   to the EKF datapath and the controller status/operand outputs.
//
//   Command channel : cmd_val, cmd_rdy, cmd_op, cmd_lk, cmd_d, cmd_a
//   Stage handshake : stage_val (one-hot predict/newlm/update), stage_rdy
//   Map / operands  : landmark_num, l_k, vlr, rk, alpha, phi
//   Status          : busy, done, err, err_code
//
//   master : host and datapath side (drives commands and stage_rdy)
//   slave  : the controller itself
interface ekf_stage_ctrl_if #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10
);

  logic               cmd_val;
  logic               cmd_rdy;
  logic [1:0]         cmd_op;
  logic [ROW_LEN-1:0] cmd_lk;
  logic [RSA_DW-1:0]  cmd_d;
  logic [RSA_AW-1:0]  cmd_a;

  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;

  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] l_k;
  logic [RSA_DW-1:0]  vlr;
  logic [RSA_DW-1:0]  rk;
  logic [RSA_AW-1:0]  alpha;
  logic [RSA_AW-1:0]  phi;

  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output cmd_val, cmd_op, cmd_lk, cmd_d, cmd_a, stage_rdy,
    input  cmd_rdy, stage_val, landmark_num, l_k, vlr, rk, alpha, phi,
           busy, done, err, err_code
  );

  modport slave (
    input  cmd_val, cmd_op, cmd_lk, cmd_d, cmd_a, stage_rdy,
    output cmd_rdy, stage_val, landmark_num, l_k, vlr, rk, alpha, phi,
           busy, done, err, err_code
  );

endinterface

// File: rtl/ekf_stage_ctrl.sv
// ekf_stage_ctrl
//   Sequencer for the EKF-SLAM datapath. Accepts one host command at a time
//   (predict, new landmark, update), validates it against the current map,
//   issues a one-hot stage request, follows the datapath through its
//   ready-high / ready-low / ready-high handshake and reports completion
//   or error. A per-state watchdog aborts a stage that stops responding.
//
//   Ports
//     clk      : sole clock, rising edge
//     sys_rst  : asynchronous active-low reset
//     bus      : ekf_stage_ctrl_if slave modport (command channel, stage
//                handshake, map count, registered operands, status)
//
//   All outputs are registered.
module ekf_stage_ctrl #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10,
  parameter int MAX_LM  = 500,
  parameter int TO_DW   = 16
) (
  input  logic               clk,
  input  logic               sys_rst,
  ekf_stage_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic [1:0] OP_PREDICT = 2'd0;
  localparam logic [1:0] OP_NEWLM   = 2'd1;
  localparam logic [1:0] OP_UPDATE  = 2'd2;

  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_FULL  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  // The counter is cleared on entry to a state, so the cycle in which it
  // reads all-ones-minus-one is the (2^TO_DW-1)-th cycle spent there: the
  // timeout fires at the end of that cycle.
  localparam logic [TO_DW-1:0]   WD_LAST = {{(TO_DW-1){1'b1}}, 1'b0};
  localparam logic [ROW_LEN-1:0] LM_FULL = ROW_LEN'(MAX_LM);

  state_e             state_q, state_d;
  logic [2:0]         stage_val_q, stage_val_d;
  logic [2:0]         sel_q, sel_d;
  logic [ROW_LEN-1:0] lm_num_q, lm_num_d;
  logic [ROW_LEN-1:0] l_k_q, l_k_d;
  logic [RSA_DW-1:0]  vlr_q, vlr_d;
  logic [RSA_DW-1:0]  rk_q, rk_d;
  logic [RSA_AW-1:0]  alpha_q, alpha_d;
  logic [RSA_AW-1:0]  phi_q, phi_d;
  logic [TO_DW-1:0]   wd_q, wd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [2:0]         op_onehot;
  logic               wd_expired;
  logic               sel_rdy;

  assign op_onehot  = 3'b001 << bus.cmd_op;
  assign wd_expired = (wd_q == WD_LAST);
  // sel_q remembers which stage is in flight after stage_val has dropped.
  assign sel_rdy    = |(sel_q & bus.stage_rdy);

  always_comb begin
    state_d     = state_q;
    stage_val_d = stage_val_q;
    sel_d       = sel_q;
    lm_num_d    = lm_num_q;
    l_k_d       = l_k_q;
    vlr_d       = vlr_q;
    rk_d        = rk_q;
    alpha_d     = alpha_q;
    phi_d       = phi_q;
    wd_d        = wd_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        // cmd_rdy_q is low in the first cycle after reset, so commands are
        // only taken once the host has seen ready.
        if (bus.cmd_val && cmd_rdy_q) begin
          if (bus.cmd_op == 2'd3) begin
            err_d      = 1'b1;
            err_code_d = ERR_ABORT;
          end else if (bus.cmd_op == OP_UPDATE && bus.cmd_lk >= lm_num_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
          end else if (bus.cmd_op == OP_NEWLM && lm_num_q == LM_FULL) begin
            err_d      = 1'b1;
            err_code_d = ERR_FULL;
          end else begin
            state_d     = ISSUE;
            stage_val_d = op_onehot;
            sel_d       = op_onehot;
            case (bus.cmd_op)
              OP_PREDICT: begin
                vlr_d   = bus.cmd_d;
                alpha_d = bus.cmd_a;
              end
              OP_NEWLM: begin
                rk_d  = bus.cmd_d;
                phi_d = bus.cmd_a;
                l_k_d = lm_num_q;
              end
              default: begin
                rk_d  = bus.cmd_d;
                phi_d = bus.cmd_a;
                l_k_d = bus.cmd_lk;
              end
            endcase
          end
        end
      end

      // A response arriving in the watchdog's last cycle still counts.
      ISSUE: begin
        if (|(stage_val_q & bus.stage_rdy)) begin
          stage_val_d = '0;
          state_d     = RUN;
          wd_d        = '0;
        end else if (wd_expired) begin
          stage_val_d = '0;
          err_d       = 1'b1;
          err_code_d  = ERR_ABORT;
          state_d     = IDLE;
          wd_d        = '0;
        end else begin
          wd_d = wd_q + TO_DW'(1);
        end
      end

      // Ready dropping is the datapath's acknowledgement that it started.
      RUN: begin
        if (!sel_rdy) begin
          state_d = WAIT;
          wd_d    = '0;
        end else if (wd_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_ABORT;
          state_d    = IDLE;
          wd_d       = '0;
        end else begin
          wd_d = wd_q + TO_DW'(1);
        end
      end

      WAIT: begin
        if (sel_rdy) begin
          done_d  = 1'b1;
          state_d = IDLE;
          wd_d    = '0;
          if (sel_q[1]) begin
            lm_num_d = lm_num_q + ROW_LEN'(1);
          end
        end else if (wd_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_ABORT;
          state_d    = IDLE;
          wd_d       = '0;
        end else begin
          wd_d = wd_q + TO_DW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        stage_val_d = '0;
        wd_d        = '0;
      end
    endcase

    // Ready/busy are registered versions of where the FSM is going, so
    // they line up with state_q in the following cycle.
    cmd_rdy_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      stage_val_q <= '0;
      sel_q       <= '0;
      lm_num_q    <= '0;
      l_k_q       <= '0;
      vlr_q       <= '0;
      rk_q        <= '0;
      alpha_q     <= '0;
      phi_q       <= '0;
      wd_q        <= '0;
      cmd_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      stage_val_q <= stage_val_d;
      sel_q       <= sel_d;
      lm_num_q    <= lm_num_d;
      l_k_q       <= l_k_d;
      vlr_q       <= vlr_d;
      rk_q        <= rk_d;
      alpha_q     <= alpha_d;
      phi_q       <= phi_d;
      wd_q        <= wd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.cmd_rdy      = cmd_rdy_q;
  assign bus.stage_val    = stage_val_q;
  assign bus.landmark_num = lm_num_q;
  assign bus.l_k          = l_k_q;
  assign bus.vlr          = vlr_q;
  assign bus.rk           = rk_q;
  assign bus.alpha        = alpha_q;
  assign bus.phi          = phi_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.err_code     = err_code_q;

endmodule
